// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, FSM states,
// ALU operation codes and PC source selects.
package mctrl_pkg;

  localparam logic [2:0] OP_LI   = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_SLTI = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_JUMP = 3'd7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_SLT    = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Opcodes whose second ALU operand is the instruction immediate.
  function automatic logic uses_imm(logic [2:0] op);
    return (op == OP_LI) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational mapping from (opcode, lireg) to the 2-bit ALU operation code.
module alu_op_decode
  import mctrl_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic       lireg,
  output logic [1:0] alu_con
);

  always_comb begin
    // NOTE: default assigned before the case so no latch is inferred.
    alu_con = ALU_ADD;
    case (opcode)
      OP_LI:   if (lireg) alu_con = ALU_PASS_B;
      OP_BEQ:  alu_con = ALU_SUB;
      OP_SLTI: alu_con = ALU_SLT;
      default: alu_con = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) for the 8-bit processor.
// Optional retired-instruction counter enabled by defining MCTRL_RETIRE_CNT_EN.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int IW          = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [IW-1:0] instr,
  input  logic          mem_ready,
  input  logic          zero,
  output logic          mem_req,
  output logic          mem_we,
  output logic          ir_we,
  output logic          pc_we,
  output logic [1:0]    pc_src,
  output logic          alu_src_b,
  output logic [1:0]    alu_con,
  output logic          reg_we,
  output logic          mem_to_reg,
  output logic          retire,
  output logic          err,
  output logic [2:0]    state,
  output logic [15:0]   retire_cnt
);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] ir;
  logic [7:0]    wait_cnt;
  logic          err_q;
  logic [2:0]    opcode;
  logic          lireg;
  logic          is_lw, is_sw;
  logic [1:0]    dec_alu_con;
  logic          mem_phase, timeout, entering_wait;
  logic          unused_operand;

  assign opcode = ir[IW-1 -: 3];
  assign lireg  = ir[IW-4];
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  // Operand fields are consumed by the datapath, not by the controller.
  assign unused_operand = ^ir[IW-5:0];

  alu_op_decode u_alu_op_decode (
    .opcode  (opcode),
    .lireg   (lireg),
    .alu_con (dec_alu_con)
  );

  // The limit cycle still completes normally if mem_ready arrives in it.
  assign mem_phase     = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout       = mem_phase && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign entering_wait = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_INC;
    alu_src_b  = 1'b0;
    alu_con    = ALU_ADD;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_IDLE: if (run && !err_q) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_src_b = uses_imm(opcode);
        alu_con   = dec_alu_con;
        case (opcode)
          OP_BEQ: begin
            pc_we  = zero;
            pc_src = PC_BRANCH;
            retire = 1'b1;
          end
          OP_JUMP: begin
            pc_we  = 1'b1;
            pc_src = PC_JUMP;
            retire = 1'b1;
          end
          OP_LW, OP_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        alu_src_b = 1'b1;
        if (mem_ready) begin
          if (is_sw) retire = 1'b1;
          else       state_d = ST_WB;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = is_lw;
        retire     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (retire) state_d = run ? ST_FETCH : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (ir_we) ir <= instr;
      if (timeout) err_q <= 1'b1;
      if (entering_wait)               wait_cnt <= '0;
      else if (mem_phase && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign state = state_q;
  assign err   = err_q;

`ifdef MCTRL_RETIRE_CNT_EN
  logic [15:0] rcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rcnt <= '0;
    else if (retire) rcnt <= rcnt + 16'd1;
  end
  assign retire_cnt = rcnt;
`else
  assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected output traces are
// built from the instruction rules and compared cycle by cycle by a separate monitor.
module tb_multicycle_ctrl;
  import mctrl_pkg::ST_IDLE;

  localparam int TO = 15;
`ifdef MCTRL_RETIRE_CNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  localparam logic [2:0] LI = 3'd0, LW = 3'd1, SW = 3'd2, ADDI = 3'd3;
  localparam logic [2:0] BEQ = 3'd4, SLTI = 3'd5, JUMP = 3'd7;

  logic        clk, rst_n, run, mem_ready, zero;
  logic [7:0]  instr;
  logic        mem_req, mem_we, ir_we, pc_we, alu_src_b, reg_we, mem_to_reg, retire, err;
  logic [1:0]  pc_src, alu_con;
  logic [2:0]  state;
  logic [15:0] retire_cnt;

  multicycle_ctrl #(.IW(8), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_ready(mem_ready),
    .zero(zero), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_con(alu_con), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .retire(retire), .err(err), .state(state),
    .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        alu_src_b;
    logic [1:0]  alu_con;
    logic        reg_we;
    logic        mem_to_reg;
    logic        retire;
    logic        err;
    logic        idle;
    logic [15:0] retire_cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_exp, mon_act;
  int          checks = 0;
  int          errors = 0;
  logic        err_m = 1'b0;
  logic [15:0] n_ret = 16'h0;
  bit          in_idle = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: dut=%h model=%h", name, act, exp);
    end
  endtask

  // Monitor: one expected vector per clock, compared away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        mon_act = '0;
        mon_act.mem_req    = mem_req;
        mon_act.mem_we     = mem_we;
        mon_act.ir_we      = ir_we;
        mon_act.pc_we      = pc_we;
        mon_act.pc_src     = pc_src;
        mon_act.alu_src_b  = alu_src_b;
        mon_act.alu_con    = alu_con;
        mon_act.reg_we     = reg_we;
        mon_act.mem_to_reg = mem_to_reg;
        mon_act.retire     = retire;
        mon_act.err        = err;
        mon_act.idle       = (state == ST_IDLE);
        mon_act.retire_cnt = retire_cnt;
        check($sformatf("cycle@%0t", $time), mon_act, mon_exp);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  function automatic exp_t blank(input bit idle);
    exp_t e = '0;
    e.idle = idle;
    return e;
  endfunction

  function automatic exp_t e_fetch(input bit done);
    exp_t e = blank(1'b0);
    e.mem_req = 1'b1;
    e.ir_we   = done;
    e.pc_we   = done;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [2:0] op, input logic lr, input logic z);
    exp_t e = blank(1'b0);
    if (op == LI && lr)  e.alu_con = 2'b11;
    else if (op == BEQ)  e.alu_con = 2'b01;
    else if (op == SLTI) e.alu_con = 2'b10;
    e.alu_src_b = (op == LI) || (op == LW) || (op == SW) || (op == ADDI) || (op == SLTI);
    if (op == BEQ)  begin e.pc_we = z;    e.pc_src = 2'b01; e.retire = 1'b1; end
    if (op == JUMP) begin e.pc_we = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1; end
    return e;
  endfunction

  function automatic exp_t e_mem(input logic [2:0] op, input bit done);
    exp_t e = blank(1'b0);
    e.mem_req   = 1'b1;
    e.mem_we    = (op == SW);
    e.alu_src_b = 1'b1;
    e.retire    = done && (op == SW);
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [2:0] op);
    exp_t e = blank(1'b0);
    e.reg_we     = 1'b1;
    e.mem_to_reg = (op == LW);
    e.retire     = 1'b1;
    return e;
  endfunction

  // Stamp the architectural state (err, retire count) and hand to the scoreboard.
  task automatic push(input exp_t e);
    e.err        = err_m;
    e.retire_cnt = RC_EN ? n_ret : 16'h0;
    sb.push_back(e);
    if (e.retire) n_ret = n_ret + 16'd1;
  endtask

  task automatic issue(input logic rdy, input logic z, input logic r,
                       input logic [7:0] ins, input exp_t e);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero      = z;
    run       = r;
    instr     = ins;
    push(e);
  endtask

  task automatic do_reset();
    err_m = 1'b0;
    n_ret = 16'h0;
    repeat (3) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0; run = rb(); mem_ready = rb(); zero = rb(); instr = rbyte();
      push(blank(1'b1));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; run = 1'b0;
    push(blank(1'b1));
    in_idle = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic r);
    for (int i = 0; i < n; i++) issue(rb(), rb(), r, rbyte(), blank(1'b1));
  endtask

  // One instruction: fw/mw are mem_ready=0 cycles in FETCH/MEM (TO means never ready).
  task automatic run_instr(input logic [7:0] ins, input logic z, input int fw,
                           input int mw, input logic rd);
    logic [2:0] op;
    op = ins[7:5];
    if (in_idle) issue(rb(), rb(), 1'b1, rbyte(), blank(1'b1));
    for (int i = 0; i < fw; i++) issue(1'b0, rb(), rd, rbyte(), e_fetch(1'b0));
    if (fw >= TO) begin
      err_m = 1'b1; in_idle = 1'b1;
      return;
    end
    issue(1'b1, rb(), rd, ins, e_fetch(1'b1));
    issue(rb(), rb(), rd, rbyte(), blank(1'b0));
    issue(rb(), z, rd, rbyte(), e_exec(op, ins[4], z));
    if (op == LW || op == SW) begin
      for (int i = 0; i < mw; i++) issue(1'b0, rb(), rd, rbyte(), e_mem(op, 1'b0));
      if (mw >= TO) begin
        err_m = 1'b1; in_idle = 1'b1;
        return;
      end
      issue(1'b1, rb(), rd, rbyte(), e_mem(op, 1'b1));
    end
    if (op != BEQ && op != JUMP && op != SW) issue(rb(), rb(), rd, rbyte(), e_wb(op));
    in_idle = !rd;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; instr = 8'h00;
    do_reset();

    run_instr(8'hC0, 1'b0, 0, 0, 1'b1);   // add
    run_instr(8'h10, 1'b0, 0, 0, 1'b1);   // li, lireg=1
    run_instr(8'h00, 1'b0, 0, 0, 1'b1);   // li, lireg=0
    run_instr(8'h80, 1'b1, 0, 0, 1'b1);   // beq taken
    run_instr(8'h80, 1'b0, 0, 0, 1'b1);   // beq not taken
    run_instr(8'h20, 1'b0, 0, 3, 1'b1);   // lw, 3 stall cycles in MEM
    run_instr(8'h40, 1'b0, 0, 0, 1'b0);   // sw with run dropped
    idle_cycles(3, 1'b0);
    run_instr(8'h25, 1'b0, TO - 1, TO - 1, 1'b1);  // ready on the limit cycle

    for (int n = 0; n < 150; n++) begin
      int fw, mw;
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      if (in_idle) idle_cycles(int'($urandom_range(0, 2)), 1'b0);
      run_instr(rbyte(), rb(), fw, mw, ($urandom_range(0, 7) != 0));
    end

    run_instr(rbyte(), rb(), TO, 0, 1'b1);   // fetch never completes
    idle_cycles(4, 1'b1);
    do_reset();
    run_instr(8'h2A, rb(), 2, TO, 1'b1);     // lw whose data never arrives
    idle_cycles(3, 1'b1);
    do_reset();

    // Reset asserted while an add sits in EXEC.
    issue(rb(), rb(), 1'b1, rbyte(), blank(1'b1));
    issue(1'b1, rb(), 1'b1, 8'hC0, e_fetch(1'b1));
    issue(rb(), rb(), 1'b1, rbyte(), blank(1'b0));
    issue(rb(), rb(), 1'b1, rbyte(), e_exec(3'd6, 1'b0, 1'b0));
    do_reset();
    run_instr(8'h70, 1'b0, 1, 0, 1'b0);      // addi after recovery
    idle_cycles(2, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors never compared, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
